shift_xfer_ctrl: RTL and testbench

SHIFT_XFER_CTRL -- requirements
Module: shift_xfer_ctrl

---
 rtl/shift_xfer_pkg.sv | 17 +
 rtl/bidir_shreg.sv | 38 +++
 rtl/shift_xfer_ctrl.sv | 141 ++++++++++++++
 tb/tb_shift_xfer_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_xfer_pkg.sv
// Shared types and constants for the serial transfer controller.
// The PARITY state exists only when SHIFT_XFER_PARITY_EN is defined.
package shift_xfer_pkg;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DONE   = 2'd2
`ifdef SHIFT_XFER_PARITY_EN
    ,ST_PARITY = 2'd3
`endif
  } xfer_state_e;

endpackage

// File: rtl/bidir_shreg.sv
// WIDTH-bit shift register: sync clear, parallel load, and shift in either direction.
// q_nxt exposes the value the register takes at the coming edge.
import shift_xfer_pkg::*;

module bidir_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = load_data;
    end else if (shift) begin
      if (dir == DIR_MSB_FIRST) q_nxt = {q[WIDTH-2:0], ser_in};
      else                      q_nxt = {ser_in, q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    q <= q_nxt;
  end

  assign ser_out = (dir == DIR_MSB_FIRST) ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Serial transfer controller: loads a word on handshake, shifts it out while shifting ser_in in.
// Define SHIFT_XFER_PARITY_EN to append a parity bit cycle and the parity_err output.
import shift_xfer_pkg::*;

module shift_xfer_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             dir,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
`ifdef SHIFT_XFER_PARITY_EN
  ,output logic            parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  xfer_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic             hs;
  logic             shift_en;
  logic             capture;
  logic             shreg_so;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_nxt;
`ifdef SHIFT_XFER_PARITY_EN
  logic             tx_par;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    ser_en      = 1'b0;
    shift_en    = 1'b0;
    capture     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy        = 1'b0;
        start_ready = 1'b1;
        if (start_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_en   = 1'b1;
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef SHIFT_XFER_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_DONE;
          capture   = 1'b1;
`endif
        end
      end
`ifdef SHIFT_XFER_PARITY_EN
      ST_PARITY: begin
        ser_en    = 1'b1;
        capture   = 1'b1;
        state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done        = 1'b1;
        start_ready = 1'b1;
        state_nxt   = start_valid ? ST_SHIFT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign hs = start_valid && start_ready;

  // Counter, direction and received word; capture grabs the register value after the last shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dir_q   <= DIR_LSB_FIRST;
      rx_data <= '0;
`ifdef SHIFT_XFER_PARITY_EN
      tx_par     <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (hs) begin
        cnt   <= '0;
        dir_q <= dir;
`ifdef SHIFT_XFER_PARITY_EN
        tx_par <= ^tx_data;
`endif
      end else if (shift_en && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        rx_data <= shreg_nxt;
`ifdef SHIFT_XFER_PARITY_EN
        parity_err <= ser_in ^ (^shreg_nxt);
`endif
      end
    end
  end

  bidir_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk      (clk),
    .clr      (rst),
    .load     (hs),
    .shift    (shift_en),
    .dir      (dir_q),
    .load_data(tx_data),
    .ser_in   (ser_in),
    .ser_out  (shreg_so),
    .q        (shreg_q),
    .q_nxt    (shreg_nxt)
  );

`ifdef SHIFT_XFER_PARITY_EN
  assign ser_out = (state == ST_PARITY) ? tx_par : (shift_en & shreg_so);
`else
  assign ser_out = shift_en & shreg_so;
`endif

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Bench for shift_xfer_ctrl (WIDTH=4): expected bits and words are queued at handshake and popped per cycle.
`timescale 1ns/1ps
module tb_shift_xfer_ctrl;

  localparam int W = 4;
`ifdef SHIFT_XFER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         dir = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         ser_in;
  logic         ser_out;
  logic         ser_en;
  logic         busy;
  logic         done;
  logic [W-1:0] rx_data;
`ifdef SHIFT_XFER_PARITY_EN
  logic         parity_err;
`endif

  logic loop_en = 1'b0;
  logic ser_drv = 1'b0;
  logic inv = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic         q_bits[$];
  logic [W-1:0] q_rx[$];

  always #5 clk = ~clk;

  always_comb ser_in = loop_en ? (ser_out ^ inv) : ser_drv;

  shift_xfer_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .dir        (dir),
    .tx_data    (tx_data),
    .ser_in     (ser_in),
    .ser_out    (ser_out),
    .ser_en     (ser_en),
    .busy       (busy),
    .done       (done),
    .rx_data    (rx_data)
`ifdef SHIFT_XFER_PARITY_EN
    ,.parity_err(parity_err)
`endif
  );

  // Reference model: per-cycle transmit bits and the word assembled from what ser_in will carry.
  task automatic push_xfer(input logic d, input logic [W-1:0] data);
    logic [W-1:0] rx;
    logic b, r;
    rx = '0;
    for (int k = 1; k <= W; k++) begin
      b = d ? data[W-k] : data[k-1];
      r = loop_en ? b : ser_drv;
      q_bits.push_back(b);
      if (d) rx[W-k] = r;
      else   rx[k-1] = r;
    end
    if (PAR != 0) q_bits.push_back(^data);
    q_rx.push_back(rx);
  endtask

  task automatic start_xfer(input logic d, input logic [W-1:0] data);
    start_valid = 1'b1;
    dir         = d;
    tx_data     = data;
    push_xfer(d, data);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({start_ready, busy, done, ser_en, ser_out} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy/busy/done/en/out=%b want 10000", {start_ready, busy, done, ser_en, ser_out});
    end
    n_tests++;
    if (rx_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rx got %b want 0000", rx_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_msb_loopback;
    logic eb;
    logic [W-1:0] er;
    @(posedge clk); #1;
    loop_en = 1'b1;
    start_xfer(1'b1, 4'b1011);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      eb = q_bits.pop_front();
      n_tests++;
      if ({ser_en, ser_out, done, start_ready} !== {1'b1, eb, 2'b00}) begin
        n_fail++;
        $display("FAIL msb_bit%0d got en/out/done/rdy=%b want %b", k + 1, {ser_en, ser_out, done, start_ready}, {1'b1, eb, 2'b00});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    er = q_rx.pop_front();
    n_tests++;
    if ({done, ser_en, busy} !== 3'b101 || rx_data !== er) begin
      n_fail++;
      $display("FAIL msb_done got done/en/busy=%b rx=%b want 101 rx=%b", {done, ser_en, busy}, rx_data, er);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({done, busy} !== 2'b00 || rx_data !== er) begin
      n_fail++;
      $display("FAIL msb_after got done/busy=%b rx=%b want 00 rx=%b", {done, busy}, rx_data, er);
    end
  endtask

  task automatic test_lsb;
    logic eb;
    logic [W-1:0] er;
    logic [W-1:0] words[2];
    logic         loops[2];
    words[0] = 4'b1011; loops[0] = 1'b0;
    words[1] = W'($urandom_range(0, 15)); loops[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      loop_en = loops[t];
      ser_drv = 1'b0;
      start_xfer(1'b0, words[t]);
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        eb = q_bits.pop_front();
        n_tests++;
        if ({ser_en, ser_out, done} !== {1'b1, eb, 1'b0}) begin
          n_fail++;
          $display("FAIL lsb%0d_bit%0d got en/out/done=%b want %b", t, k + 1, {ser_en, ser_out, done}, {1'b1, eb, 1'b0});
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      er = q_rx.pop_front();
      n_tests++;
      if (done !== 1'b1 || rx_data !== er) begin
        n_fail++;
        $display("FAIL lsb%0d_done got done=%b rx=%b want 1 rx=%b", t, done, rx_data, er);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic eb;
    logic [W-1:0] er;
    @(posedge clk); #1;
    loop_en     = 1'b1;
    start_valid = 1'b1;
    dir         = 1'b1;
    tx_data     = 4'b0110;
    push_xfer(1'b1, 4'b0110);
    push_xfer(1'b1, 4'b0110);
    @(posedge clk); #1;
    for (int x = 0; x < 2; x++) begin
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        eb = q_bits.pop_front();
        n_tests++;
        if ({ser_en, ser_out, done, start_ready} !== {1'b1, eb, 2'b00}) begin
          n_fail++;
          $display("FAIL b2b%0d_bit%0d got en/out/done/rdy=%b want %b", x, k + 1, {ser_en, ser_out, done, start_ready}, {1'b1, eb, 2'b00});
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      er = q_rx.pop_front();
      n_tests++;
      if ({done, start_ready, ser_en} !== 3'b110 || rx_data !== er) begin
        n_fail++;
        $display("FAIL b2b%0d_done got done/rdy/en=%b rx=%b want 110 rx=%b", x, {done, start_ready, ser_en}, rx_data, er);
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done, ser_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle got busy/done/en=%b want 000", {busy, done, ser_en});
    end
  endtask

  task automatic test_ignore_midshift;
    logic eb;
    logic [W-1:0] er;
    @(posedge clk); #1;
    loop_en = 1'b1;
    start_xfer(1'b1, 4'b1011);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      eb = q_bits.pop_front();
      n_tests++;
      if ({ser_en, ser_out, done} !== {1'b1, eb, 1'b0}) begin
        n_fail++;
        $display("FAIL ignore_bit%0d got en/out/done=%b want %b", k + 1, {ser_en, ser_out, done}, {1'b1, eb, 1'b0});
      end
      @(posedge clk); #1;
      if (k == 0) begin
        start_valid = 1'b1;
        tx_data     = 4'b1111;
        dir         = 1'b0;
      end else begin
        start_valid = 1'b0;
      end
    end
    @(negedge clk);
    er = q_rx.pop_front();
    n_tests++;
    if (done !== 1'b1 || rx_data !== er) begin
      n_fail++;
      $display("FAIL ignore_done got done=%b rx=%b want 1 rx=%b", done, rx_data, er);
    end
  endtask

  task automatic test_abort;
    logic saw_done;
    @(posedge clk); #1;
    loop_en = 1'b1;
    start_xfer(1'b1, 4'b1011);
    @(negedge clk);
    n_tests++;
    if (ser_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_bit1 got en=%b want 1", ser_en);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_bits.delete();
    q_rx.delete();
    @(negedge clk);
    n_tests++;
    if ({busy, ser_en, start_ready, done} !== 4'b0010 || rx_data !== '0) begin
      n_fail++;
      $display("FAIL abort_state got busy/en/rdy/done=%b rx=%b want 0010 rx=0000", {busy, ser_en, start_ready, done}, rx_data);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 2 * NB; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_nodone got done pulse=%b want 0", saw_done);
    end
    @(posedge clk); #1;
    start_valid = 1'b1;
    tx_data     = 4'b1011;
    rst         = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    rst         = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, ser_en, start_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_prio got busy/en/rdy=%b want 001", {busy, ser_en, start_ready});
    end
  endtask

`ifdef SHIFT_XFER_PARITY_EN
  task automatic test_parity;
    logic eb;
    logic [W-1:0] er;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      loop_en = 1'b1;
      inv     = 1'b0;
      start_xfer(1'b1, 4'b1011);
      for (int k = 0; k < NB; k++) begin
        @(negedge clk);
        eb = q_bits.pop_front();
        n_tests++;
        if ({ser_en, ser_out, done} !== {1'b1, eb, 1'b0}) begin
          n_fail++;
          $display("FAIL par%0d_bit%0d got en/out/done=%b want %b", r, k + 1, {ser_en, ser_out, done}, {1'b1, eb, 1'b0});
        end
        @(posedge clk); #1;
        if (k == W - 1) inv = (r == 1);
      end
      @(negedge clk);
      inv = 1'b0;
      er = q_rx.pop_front();
      n_tests++;
      if (done !== 1'b1 || rx_data !== er || parity_err !== (r == 1)) begin
        n_fail++;
        $display("FAIL par%0d_done got done=%b rx=%b perr=%b want 1 rx=%b perr=%b", r, done, rx_data, parity_err, er, (r == 1));
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_msb_loopback();
    test_lsb();
    test_back_to_back();
    test_ignore_midshift();
    test_abort();
`ifdef SHIFT_XFER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
